sync_fifo_ctrl: RTL and testbench
=================================

# sync_fifo_ctrl

Parametrised single-clock FIFO for buffering word streams inside one clock domain, e.g. ahead of the UART TX path once data is already in the 50 MHz domain. Adds fill-level reporting, programmable almost-full/almost-empty thresholds, a synchronous flush, sticky overflow/underflow error flags and an optional first-word-fall-through (FWFT) read mode. Storage sits in a separate dual-port memory sub-module; pointers and flags live in this block.

## Interface
- DATA_LEN, 16, word width in bits
- FIFO_DEPTH, 512, number of words; must be a power of two, ≥ 4
- PNTR_WIDTH, $clog2(FIFO_DEPTH), address width
- AF_THRESH, FIFO_DEPTH-4, almost_full asserts when fill_count ≥ AF_THRESH
- AE_THRESH, 4, almost_empty asserts when fill_count ≤ AE_THRESH
- clk  input  1  single clock for all logic
- reset  input  1  synchronous, active-high
- flush  input  1  synchronous pointer clear; does not clear error flags
- clear_err  input  1  clears overflow/underflow sticky flags
- write_en  input  1  write request
- data_in  input  DATA_LEN  write data
- read_en  input  1  read request (pop)
- data_out  output  DATA_LEN  read data
- data_valid  output  1  data_out holds a newly popped word (standard) / head word is valid (FWFT)
- fifo_full, fifo_empty, almost_full, almost_empty  output  1 each  level flags
- fill_count  output  PNTR_WIDTH+1  words currently stored, 0..FIFO_DEPTH
- overflow, underflow  output  1 each  sticky error flags

## Operation
- Pointers rd_ptr/wr_ptr are PNTR_WIDTH+1 bits; low PNTR_WIDTH bits address memory; MSB disambiguates full vs empty; wrap is natural modulo 2^(PNTR_WIDTH+1).
- Write accepted = write_en && (!fifo_full || read accepted). Read accepted = read_en && !fifo_empty.
- Full + write_en + read_en: both accepted, fill_count unchanged. Empty + both: write accepted, read rejected.
- fill_count next = count + wr_acc − rd_acc; all four level flags derived from next-count and registered.
- overflow set when write_en && !write accepted; underflow set when read_en && fifo_empty. Sticky until clear_err or reset; clear_err and a new error in the same cycle → flag stays set.
- Priority: reset > flush > read/write. flush zeroes pointers and fill_count, forces empty flags, ignores that cycle's read/write, holds data_out value, deasserts data_valid.
- Reset: pointers 0, fill_count 0, fifo_empty 1, almost_empty 1, fifo_full 0, almost_full 0 (AF_THRESH ≥ 1), overflow/underflow 0, data_out 0, data_valid 0. Memory contents not reset.

## Timing
- Write: data_in stored at the edge where accepted; visible to a read from the next cycle.
- Flags and fill_count update on the same edge that accepts the operation (no extra latency).
- Standard mode read latency 1: read accepted at edge N → data_out updated and data_valid high for one cycle after edge N; data_out holds otherwise.
- Write into empty FIFO at edge N → fifo_empty low after N; earliest accepted read at edge N+1.

## Configuration
- SYNC_FIFO_FWFT_EN defined: data_out continuously shows the head word (asynchronous memory read of rd_ptr); data_valid = !fifo_empty; read_en pops the displayed word; word written at edge N appears on data_out after edge N.
- Not defined: standard registered-read mode as above; memory read port is synchronous (block-RAM inferable).

## Structure
- fifo_pkg: shared constants/typedefs — fifo_level_t status struct {full, empty, almost_full, almost_empty}, fifo_err_t {overflow, underflow}, default DATA_LEN/FIFO_DEPTH constants.
- Sub-module fifo_dp_mem: simple dual-port RAM, one write port, one read port (sync or async read selected by the same macro).
- Elaboration-time assertion: FIFO_DEPTH power of two, AE_THRESH < AF_THRESH ≤ FIFO_DEPTH.

## Test plan (DATA_LEN=16, FIFO_DEPTH=8, AF_THRESH=6, AE_THRESH=2)
- Write 0x0001..0x0008 → fifo_full=1, fill_count=8, almost_full from 6th write; 9th write → overflow=1, contents unchanged.
- Drain 8 reads (standard) → data_out 0x0001..0x0008 each one cycle after its read, data_valid pulses; 9th read → underflow=1, data_out holds 0x0008.
- Full + write_en + read_en for 20 cycles with incrementing data → fill_count stays 8, read order matches write order across pointer wrap.
- Fill 5, assert flush with write_en/read_en high → next cycle fill_count=0, fifo_empty=1, overflow/underflow unchanged.
- Assert reset mid-burst (count 3) → all outputs at reset values next cycle; clear_err with no error pending clears sticky flags.
- SYNC_FIFO_FWFT_EN: write 0xABCD into empty FIFO → data_out=0xABCD, data_valid=1 the next cycle with no read_en.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: types and constants shared by sync_fifo_ctrl and fifo_dp_mem.
//   fifo_level_t   - registered level flags {full, empty, almost_full, almost_empty}
//   fifo_err_t     - sticky error flags {overflow, underflow}
//   LEVEL_EMPTY    - flag values for an empty FIFO (reset / flush state)
//   is_pow2()      - constant helper for the elaboration-time parameter check
package fifo_pkg;

    localparam int DEFAULT_DATA_LEN   = 16;
    localparam int DEFAULT_FIFO_DEPTH = 512;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_level_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    // Count 0 is always <= AE_THRESH and always < AF_THRESH (AF_THRESH >= 1).
    localparam fifo_level_t LEVEL_EMPTY = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_dp_mem.sv
// fifo_dp_mem: simple dual-port RAM, one write port and one read port, one clock.
// Macro SYNC_FIFO_FWFT_EN:
//   defined     - asynchronous read, rd_data = mem[rd_addr] combinationally
//   not defined - synchronous read register (block-RAM style) with synchronous
//                 reset rd_rst and read enable rd_en; rd_data holds when idle
// Ports:
//   clk      - clock
//   rd_rst   - (sync read only) clears the read register to 0
//   rd_en    - (sync read only) load read register from mem[rd_addr]
//   wr_en    - write mem[wr_addr] <= wr_data
//   wr_addr, wr_data, rd_addr, rd_data - address/data buses
module fifo_dp_mem #(
    parameter int DATA_LEN   = 16,
    parameter int PNTR_WIDTH = 9
) (
    input  logic                  clk,
`ifndef SYNC_FIFO_FWFT_EN
    input  logic                  rd_rst,
    input  logic                  rd_en,
`endif
    input  logic                  wr_en,
    input  logic [PNTR_WIDTH-1:0] wr_addr,
    input  logic [DATA_LEN-1:0]   wr_data,
    input  logic [PNTR_WIDTH-1:0] rd_addr,
    output logic [DATA_LEN-1:0]   rd_data
);

    logic [DATA_LEN-1:0] mem [0:(1 << PNTR_WIDTH) - 1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data = mem[rd_addr];
`else
    // Read-before-write: when full with simultaneous read and write, both
    // ports hit the same address and the read must return the old head word.
    always_ff @(posedge clk) begin
        if (rd_rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
`endif

endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO controller with fill level, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
// Macro SYNC_FIFO_FWFT_EN: defined -> first-word-fall-through read mode
// (data_out shows the head word, data_valid = !fifo_empty); undefined ->
// registered read, data_out/data_valid one cycle after an accepted read.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   flush                 - clears pointers/count, ignores that cycle's read/write
//   clear_err             - clears overflow/underflow (a new error wins)
//   write_en, data_in     - write request and data
//   read_en               - read request (pop)
//   data_out, data_valid  - read data and its qualifier
//   fifo_full, fifo_empty, almost_full, almost_empty - registered level flags
//   fill_count            - words stored, 0..FIFO_DEPTH
//   overflow, underflow   - sticky error flags
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_LEN   = DEFAULT_DATA_LEN,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int PNTR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int AF_THRESH  = FIFO_DEPTH - 4,
    parameter int AE_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  clear_err,
    input  logic                  write_en,
    input  logic [DATA_LEN-1:0]   data_in,
    input  logic                  read_en,
    output logic [DATA_LEN-1:0]   data_out,
    output logic                  data_valid,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PNTR_WIDTH:0]   fill_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CW = PNTR_WIDTH + 1;
    localparam logic [PNTR_WIDTH:0] FULL_LVL = FIFO_DEPTH[PNTR_WIDTH:0];
    localparam logic [PNTR_WIDTH:0] AF_LVL   = AF_THRESH[PNTR_WIDTH:0];
    localparam logic [PNTR_WIDTH:0] AE_LVL   = AE_THRESH[PNTR_WIDTH:0];

    if (!(is_pow2(FIFO_DEPTH) && FIFO_DEPTH >= 4 && PNTR_WIDTH == $clog2(FIFO_DEPTH) &&
          AE_THRESH >= 0 && AF_THRESH >= 1 && AE_THRESH < AF_THRESH &&
          AF_THRESH <= FIFO_DEPTH)) begin : g_bad_cfg
        $error("sync_fifo_ctrl: illegal FIFO_DEPTH/AF_THRESH/AE_THRESH combination");
    end

    logic [PNTR_WIDTH:0] wr_ptr, rd_ptr;
    logic [PNTR_WIDTH:0] wr_ptr_nxt, rd_ptr_nxt, next_count;
    logic                rd_acc, wr_acc, ops_live;
    fifo_level_t         level_q, level_nxt;
    fifo_err_t           err_q, err_nxt;
    logic [DATA_LEN-1:0] rd_data;

    always_comb begin
        ops_live   = !reset && !flush;
        rd_acc     = read_en && !level_q.empty;
        // A read frees a slot in the same cycle, so a full FIFO still accepts.
        wr_acc     = write_en && (!level_q.full || rd_acc);
        wr_ptr_nxt = wr_ptr + CW'(wr_acc);
        rd_ptr_nxt = rd_ptr + CW'(rd_acc);
        // Natural modulo-2^CW wrap keeps the difference equal to the fill level.
        next_count = wr_ptr_nxt - rd_ptr_nxt;

        level_nxt              = LEVEL_EMPTY;
        level_nxt.full         = (next_count == FULL_LVL);
        level_nxt.empty        = (next_count == '0);
        level_nxt.almost_full  = (next_count >= AF_LVL);
        level_nxt.almost_empty = (next_count <= AE_LVL);

        // Errors are not detected on a flush cycle since its requests are ignored.
        err_nxt           = err_q;
        err_nxt.overflow  = (err_q.overflow && !clear_err) ||
                            (!flush && write_en && !wr_acc);
        err_nxt.underflow = (err_q.underflow && !clear_err) ||
                            (!flush && read_en && level_q.empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
            level_q    <= LEVEL_EMPTY;
            err_q      <= '0;
        end else begin
            err_q <= err_nxt;
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fill_count <= '0;
                level_q    <= LEVEL_EMPTY;
            end else begin
                wr_ptr     <= wr_ptr_nxt;
                rd_ptr     <= rd_ptr_nxt;
                fill_count <= next_count;
                level_q    <= level_nxt;
            end
        end
    end

    fifo_dp_mem #(
        .DATA_LEN   (DATA_LEN),
        .PNTR_WIDTH (PNTR_WIDTH)
    ) u_mem (
        .clk     (clk),
`ifndef SYNC_FIFO_FWFT_EN
        .rd_rst  (reset),
        .rd_en   (rd_acc && ops_live),
`endif
        .wr_en   (wr_acc && ops_live),
        .wr_addr (wr_ptr[PNTR_WIDTH-1:0]),
        .wr_data (data_in),
        .rd_addr (rd_ptr[PNTR_WIDTH-1:0]),
        .rd_data (rd_data)
    );

    assign data_out = rd_data;

`ifdef SYNC_FIFO_FWFT_EN
    assign data_valid = !level_q.empty;
`else
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_acc;
        end
    end
`endif

    assign fifo_full    = level_q.full;
    assign fifo_empty   = level_q.empty;
    assign almost_full  = level_q.almost_full;
    assign almost_empty = level_q.almost_empty;
    assign overflow     = err_q.overflow;
    assign underflow    = err_q.underflow;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Testbench for sync_fifo_ctrl (DATA_LEN=16, FIFO_DEPTH=8, AF_THRESH=6, AE_THRESH=2).
// Reference model is a word queue plus two sticky bits; popped words go to a
// scoreboard queue that a separate monitor checks whenever data_valid is seen.
module tb_sync_fifo_ctrl;

    localparam int DL    = 16;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;
    localparam int PW    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1, flush = 1'b0, clear_err = 1'b0;
    logic          write_en = 1'b0, read_en = 1'b0;
    logic [DL-1:0] data_in = '0;
    logic [DL-1:0] data_out;
    logic          data_valid, fifo_full, fifo_empty, almost_full, almost_empty;
    logic [PW:0]   fill_count;
    logic          overflow, underflow;

    sync_fifo_ctrl #(
        .DATA_LEN   (DL),
        .FIFO_DEPTH (DEPTH),
        .PNTR_WIDTH (PW),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .clear_err    (clear_err),
        .write_en     (write_en),
        .data_in      (data_in),
        .read_en      (read_en),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fill_count   (fill_count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DL-1:0] mq[$];      // model FIFO contents, head at index 0
    logic [DL-1:0] exp_q[$];   // scoreboard: words expected on data_out
    bit            m_ovf = 1'b0, m_unf = 1'b0;
    logic [DL-1:0] last_out = '0;

    // One clock cycle: drive, let the edge happen, update model, check state.
    task automatic step(input string tag, input bit we, input bit re, input bit fl,
                        input bit rs, input bit ce, input logic [DL-1:0] d);
        bit            rd_ok, wr_ok;
        int            n;
        logic [9:0]    exp_st, act_st;
        logic [DL-1:0] w;
        write_en = we; read_en = re; flush = fl; reset = rs; clear_err = ce; data_in = d;
        @(posedge clk);
        n = mq.size();
        if (rs) begin
            mq.delete();
            m_ovf = 1'b0; m_unf = 1'b0;
            last_out = '0;
        end else if (fl) begin
            mq.delete();
            m_ovf = m_ovf && !ce;
            m_unf = m_unf && !ce;
        end else begin
            rd_ok = re && (n > 0);
            wr_ok = we && ((n < DEPTH) || rd_ok);
            m_ovf = (m_ovf && !ce) || (we && !wr_ok);
            m_unf = (m_unf && !ce) || (re && (n == 0));
            if (rd_ok) begin
                w = mq.pop_front();
`ifndef SYNC_FIFO_FWFT_EN
                exp_q.push_back(w);
                last_out = w;
`endif
            end
            if (wr_ok) mq.push_back(d);
        end
        #1;
        n = mq.size();
        exp_st = {4'(n), n == DEPTH, n == 0, n >= AF, n <= AE, m_ovf, m_unf};
        act_st = {fill_count, fifo_full, fifo_empty, almost_full, almost_empty, overflow, underflow};
        checks++;
        if (act_st !== exp_st) begin
            failures++;
            $display("FAIL %s status{count,full,empty,af,ae,ovf,unf}: got %b expected %b",
                     tag, act_st, exp_st);
        end
`ifdef SYNC_FIFO_FWFT_EN
        checks++;
        if (data_valid !== (n > 0)) begin
            failures++;
            $display("FAIL %s data_valid: got %b expected %b", tag, data_valid, n > 0);
        end
        if (n > 0) begin
            checks++;
            if (data_out !== mq[0]) begin
                failures++;
                $display("FAIL %s head data_out: got %h expected %h", tag, data_out, mq[0]);
            end
        end
`else
        checks++;
        if (data_out !== last_out) begin
            failures++;
            $display("FAIL %s data_out hold: got %h expected %h", tag, data_out, last_out);
        end
`endif
    endtask

`ifndef SYNC_FIFO_FWFT_EN
    // Monitor: every presented word must be the next one the model popped.
    always @(negedge clk) begin
        logic [DL-1:0] e;
        if (data_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL monitor spurious data_valid: got data_out %h expected no word", data_out);
            end else begin
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    failures++;
                    $display("FAIL monitor read data: got %h expected %h", data_out, e);
                end
            end
        end
    end
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wp;
        step("reset", 0, 0, 0, 1, 0, '0);
        step("reset", 0, 0, 0, 1, 0, '0);

        // Fill to full, then one write too many.
        for (int unsigned i = 1; i <= 9; i++) step("fill", 1, 0, 0, 0, 0, 16'(i));
`ifdef SYNC_FIFO_FWFT_EN
        step("fwft_clear", 0, 0, 0, 0, 1, '0);
        for (int unsigned i = 0; i < 8; i++) step("fwft_drain", 0, 1, 0, 0, 0, '0);
        step("fwft_one", 1, 0, 0, 0, 0, 16'hABCD);
        step("fwft_show", 0, 0, 0, 0, 0, '0);
        step("fwft_pop", 0, 1, 0, 0, 0, '0);
`endif
        // Drain all plus one underflowing read.
        for (int unsigned i = 0; i < 9; i++) step("drain", 0, 1, 0, 0, 0, '0);
        step("drain_idle", 0, 0, 0, 0, 0, '0);
        step("clear_err", 0, 0, 0, 0, 1, '0);

        // Full with simultaneous read/write across pointer wrap.
        for (int unsigned i = 0; i < 8; i++) step("refill", 1, 0, 0, 0, 0, 16'(16'h0100 + i));
        for (int unsigned i = 0; i < 20; i++) step("full_rw", 1, 1, 0, 0, 0, 16'(16'h0200 + i));
        step("full_ovf", 1, 0, 0, 0, 0, 16'hDEAD);

        // Flush keeps the sticky flag; requests on the flush cycle are ignored.
        step("flush0", 0, 0, 1, 0, 0, '0);
        for (int unsigned i = 0; i < 5; i++) step("fill5", 1, 0, 0, 0, 0, 16'(16'h0300 + i));
        step("flush_rw", 1, 1, 1, 0, 0, 16'hBEEF);
        step("post_flush", 0, 0, 0, 0, 0, '0);
        step("empty_rw", 1, 1, 0, 0, 0, 16'h0400);
        step("read1", 0, 1, 0, 0, 0, '0);

        // Reset in the middle of a burst, then clear_err with nothing pending.
        for (int unsigned i = 0; i < 3; i++) step("burst", 1, 0, 0, 0, 0, 16'(16'h0500 + i));
        step("mid_reset", 1, 1, 0, 1, 0, 16'h0600);
        step("idle_clear", 0, 0, 0, 0, 1, '0);

        // Randomised traffic, alternating write-heavy and read-heavy phases.
        for (int unsigned i = 0; i < 600; i++) begin
            wp = ((i / 40) % 2 == 0) ? 75 : 25;
            step("random",
                 $urandom_range(0, 99) < wp,
                 $urandom_range(0, 99) < (100 - wp),
                 $urandom_range(0, 63) == 0,
                 $urandom_range(0, 149) == 0,
                 $urandom_range(0, 15) == 0,
                 16'($urandom));
        end
        step("tail", 0, 0, 0, 0, 0, '0);
        step("tail", 0, 0, 0, 0, 0, '0);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got %0d words pending expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
